// File: rtl/instr_sequencer.sv
// Eight-phase fetch/execute sequencer driving the RISC datapath control strobes.
// Define INSTR_SEQ_HALT_LATCH_EN to make HLT latch a HALTED state until reset.
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             inc_pc,
    output logic             load_acc,
    output logic             load_pc,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             datactl_ena,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       dbg_state
);

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;
    localparam logic [2:0] P5 = 3'd5;
    localparam logic [2:0] P6 = 3'd6;
    localparam logic [2:0] P7 = 3'd7;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_inc_pc, r_load_acc, r_load_pc, r_rd, r_wr;
    logic             r_load_ir, r_datactl_ena, r_halt;
    logic             w_halted;

    logic w_alu, w_skz_z, w_jmp, w_sto, w_hlt;
    logic w_inc_pc, w_load_acc, w_load_pc, w_rd, w_wr;
    logic w_load_ir, w_datactl_ena, w_halt;

    assign w_alu   = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                     (opcode == OP_XORR) || (opcode == OP_LDA);
    assign w_skz_z = (opcode == OP_SKZ) && zero;
    assign w_jmp   = (opcode == OP_JMP);
    assign w_sto   = (opcode == OP_STO);
    assign w_hlt   = (opcode == OP_HLT);

    // Strobe pattern for the current phase; registered on the next edge.
    always_comb begin
        w_inc_pc      = 1'b0;
        w_load_acc    = 1'b0;
        w_load_pc     = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_load_ir     = 1'b0;
        w_datactl_ena = 1'b0;
        w_halt        = 1'b0;
        case (r_phase)
            P0: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
            end
            P1: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
            end
            P2: ;
            P3: begin
                w_inc_pc = 1'b1;
                w_halt   = w_hlt;
            end
            P4: begin
                w_rd          = w_alu;
                w_inc_pc      = w_skz_z;
                w_load_pc     = w_jmp;
                w_datactl_ena = w_sto;
            end
            P5: begin
                w_rd          = w_alu;
                w_load_acc    = w_alu;
                w_inc_pc      = w_skz_z || w_jmp;
                w_load_pc     = w_jmp;
                w_wr          = w_sto;
                w_datactl_ena = w_sto;
            end
            P6: begin
                w_rd          = w_alu;
                w_datactl_ena = w_sto;
            end
            P7: w_inc_pc = w_skz_z;
            default: ;
        endcase
    end

`ifdef INSTR_SEQ_HALT_LATCH_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (!r_halted && ena && (r_phase == P3) && w_hlt) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase       <= P0;
            r_instr_cnt   <= '0;
            r_inc_pc      <= 1'b0;
            r_load_acc    <= 1'b0;
            r_load_pc     <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_load_ir     <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b0;
        end else if (w_halted) begin
            r_inc_pc      <= 1'b0;
            r_load_acc    <= 1'b0;
            r_load_pc     <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_load_ir     <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b1;
        end else if (!ena) begin
            r_phase       <= P0;
            r_inc_pc      <= 1'b0;
            r_load_acc    <= 1'b0;
            r_load_pc     <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_load_ir     <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            r_phase       <= r_phase + 3'd1;
            r_inc_pc      <= w_inc_pc;
            r_load_acc    <= w_load_acc;
            r_load_pc     <= w_load_pc;
            r_rd          <= w_rd;
            r_wr          <= w_wr;
            r_load_ir     <= w_load_ir;
            r_datactl_ena <= w_datactl_ena;
            r_halt        <= w_halt;
            if (r_phase == P7) begin
                r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign inc_pc      = r_inc_pc;
    assign load_acc    = r_load_acc;
    assign load_pc     = r_load_pc;
    assign rd          = r_rd;
    assign wr          = r_wr;
    assign load_ir     = r_load_ir;
    assign datactl_ena = r_datactl_ena;
    assign halt        = r_halt;
    assign instr_cnt   = r_instr_cnt;
    assign dbg_state   = {w_halted, r_phase};

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle strobe tables for each opcode class,
// ena drop, mid-instruction reset, HLT behaviour and retired-count wrap (small CNT_W).
module tb_instr_sequencer;

    localparam int TB_CNT_W = 4;

    // Strobe byte: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
    // Each table holds cycles 1..8 of one instruction, cycle 1 in the top byte.
    localparam logic [63:0] PAT_ALU  = 64'h1494_0080_1050_1000;
    localparam logic [63:0] PAT_STO  = 64'h1494_0080_020A_0200;
    localparam logic [63:0] PAT_SKZ1 = 64'h1494_0080_8080_0080;
    localparam logic [63:0] PAT_SKZ0 = 64'h1494_0080_0000_0000;
    localparam logic [63:0] PAT_JMP  = 64'h1494_0080_20A0_0000;
    localparam logic [63:0] PAT_HLT  = 64'h1494_0081_0000_0000;

    logic                clk = 1'b0;
    logic                reset, ena, zero;
    logic [2:0]          opcode;
    logic                inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
    logic [TB_CNT_W-1:0] instr_cnt;
    logic [3:0]          dbg_state;
    logic [7:0]          obs;
    logic [TB_CNT_W-1:0] exp_cnt;
    int                  n_checks = 0;
    int                  n_errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .ena(ena), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
        .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt),
        .instr_cnt(instr_cnt), .dbg_state(dbg_state)
    );

    assign obs = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic [2:0] op, input logic z);
        ena    = e;
        reset  = r;
        opcode = op;
        zero   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [63:0] pat);
        for (int c = 1; c <= 8; c++) begin
            step(1'b1, 1'b0, op, z);
            check($sformatf("%s c%0d strobes", tag, c), {24'd0, obs}, {24'd0, pat[(8-c)*8 +: 8]});
            check($sformatf("%s c%0d rd_wr", tag, c), {31'd0, rd & wr}, 32'd0);
        end
        exp_cnt = exp_cnt + 1'b1;
        check({tag, " instr_cnt"}, {28'd0, instr_cnt}, {28'd0, exp_cnt});
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b1, 3'b010, 1'b0);
        exp_cnt = '0;
        check({tag, " strobes"}, {24'd0, obs}, 32'd0);
        check({tag, " instr_cnt"}, {28'd0, instr_cnt}, 32'd0);
        check({tag, " state"}, {28'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        ena = 1'b0; reset = 1'b1; opcode = 3'b000; zero = 1'b0;
        exp_cnt = '0;
        step(1'b0, 1'b1, 3'b000, 1'b0);
        do_reset("reset");

        run_instr("ADD", 3'b010, 1'b0, PAT_ALU);
        run_instr("LDA_z1", 3'b101, 1'b1, PAT_ALU);
        run_instr("XORR", 3'b100, 1'b0, PAT_ALU);
        run_instr("STO", 3'b110, 1'b0, PAT_STO);
        run_instr("SKZ_z1", 3'b001, 1'b1, PAT_SKZ1);
        run_instr("SKZ_z0", 3'b001, 1'b0, PAT_SKZ0);
        run_instr("JMP", 3'b111, 1'b0, PAT_JMP);

`ifdef INSTR_SEQ_HALT_LATCH_EN
        for (int c = 1; c <= 4; c++) begin
            step(1'b1, 1'b0, 3'b000, 1'b0);
            check($sformatf("HLT c%0d strobes", c), {24'd0, obs}, {24'd0, PAT_HLT[(8-c)*8 +: 8]});
        end
        for (int i = 0; i < 22; i++) begin
            step(i[0], 1'b0, 3'b000, 1'b0);
            check($sformatf("HALTED %0d strobes", i), {24'd0, obs}, 32'h01);
            check($sformatf("HALTED %0d instr_cnt", i), {28'd0, instr_cnt}, {28'd0, exp_cnt});
        end
        check("HALTED state", {31'd0, dbg_state[3]}, 32'd1);
`else
        run_instr("HLT", 3'b000, 1'b0, PAT_HLT);
`endif
        do_reset("post_hlt reset");
        check("post_hlt halt", {31'd0, halt}, 32'd0);

        // ena drops while STO is at P5: no write, return to P0, then full refetch.
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, 1'b0, 3'b110, 1'b0);
            check($sformatf("STO_ena c%0d strobes", c), {24'd0, obs}, {24'd0, PAT_STO[(8-c)*8 +: 8]});
        end
        step(1'b0, 1'b0, 3'b110, 1'b0);
        check("ena_off strobes", {24'd0, obs}, 32'd0);
        check("ena_off state", {28'd0, dbg_state}, 32'd0);
        step(1'b0, 1'b0, 3'b110, 1'b0);
        check("ena_off hold cnt", {28'd0, instr_cnt}, {28'd0, exp_cnt});
        run_instr("STO_refetch", 3'b110, 1'b0, PAT_STO);

        // Reset at P5 of STO aborts before the write strobe.
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, 1'b0, 3'b110, 1'b0);
        end
        check("STO_rst pre strobes", {24'd0, obs}, 32'h02);
        do_reset("STO_rst");
        step(1'b1, 1'b0, 3'b110, 1'b0);
        check("STO_rst restart", {24'd0, obs}, 32'h14);
        do_reset("wrap reset");

        for (int n = 0; n < 16; n++) begin
            run_instr($sformatf("wrap%0d", n), 3'b010, 1'b0, PAT_ALU);
        end
        check("wrap to zero", {28'd0, instr_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
